// File: rtl/axis_rr_arbiter.sv
// Round-robin AXIS arbiter: NUM_PORTS producers share one registered output stage.
// With LOCK_ON_LAST=1 the grant is held from a packet's first beat through its last beat.
module axis_rr_arbiter #(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned LOCK_ON_LAST = 1,
    parameter int unsigned ID_WIDTH     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              input_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   input_data,
    input  logic [NUM_PORTS-1:0]              input_last,
    output logic [NUM_PORTS-1:0]              input_ready,
    output logic                              output_valid,
    output logic [DATA_WIDTH-1:0]             output_data,
    output logic                              output_last,
    output logic [ID_WIDTH-1:0]               output_id,
    input  logic                              output_ready
);

    localparam int unsigned SUM_W = ID_WIDTH + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]     lock_port_q, lock_port_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic [ID_WIDTH-1:0]     out_id_q, out_id_d;

    logic [2*NUM_PORTS-1:0]  valid_dbl;
    logic [NUM_PORTS-1:0]    valid_rot;
    logic [ID_WIDTH-1:0]     rr_off;
    logic                    rr_found;
    logic                    grant_valid;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic                    accept;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;

    // Modular add on port indices (NUM_PORTS need not be a power of two)
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] a,
                                                     input logic [ID_WIDTH-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s >= SUM_W'(NUM_PORTS)) begin
            s = s - SUM_W'(NUM_PORTS);
        end
        return s[ID_WIDTH-1:0];
    endfunction

    // Grant selection: rotated priority scan in IDLE, fixed port while LOCKED
    always_comb begin
        valid_dbl   = {input_valid, input_valid};
        valid_rot   = NUM_PORTS'(valid_dbl >> ptr_q);
        rr_found    = 1'b0;
        rr_off      = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                rr_found = 1'b1;
                rr_off   = ID_WIDTH'(k);
            end
        end
        if (state_q == LOCKED) begin
            grant_valid = input_valid[lock_port_q];
            grant_idx   = lock_port_q;
        end else begin
            grant_valid = rr_found;
            grant_idx   = wrap_add(ptr_q, rr_off);
        end
    end

    // Ready generation and payload mux for the granted port
    always_comb begin
        accept      = !out_valid_q || output_ready;
        input_ready = '0;
        if (!rst && accept && grant_valid) begin
            input_ready[grant_idx] = 1'b1;
        end
        xfer     = |input_ready;
        sel_data = input_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        sel_last = input_last[grant_idx];
    end

    // Next-state: output register load/drain, pointer advance, packet lock tracking
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_port_d = lock_port_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_id_d    = grant_idx;
            ptr_d       = wrap_add(grant_idx, ID_WIDTH'(1));
            if ((LOCK_ON_LAST != 0) && !sel_last) begin
                state_d     = LOCKED;
                lock_port_d = grant_idx;
            end else begin
                state_d     = IDLE;
            end
        end else if (out_valid_q && output_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any in-flight lock or beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_port_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_port_q <= lock_port_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;
    assign output_last  = out_last_q;
    assign output_id    = out_id_q;

`ifndef SYNTHESIS
    // At most one port is ready in any cycle
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(input_ready));

    // A stalled output beat stays put until consumed
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !output_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_last_q) && $stable(out_id_q)));
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: vector table plus packet-lock, interleave and reset sequences.
module tb_axis_rr_arbiter;

    localparam int unsigned DW = 10;
    localparam int unsigned NP = 4;

    logic clk = 1'b0;
    logic rst;

    // Packet-lock instance
    logic [NP-1:0]    in_valid, in_last, in_ready;
    logic [NP*DW-1:0] in_data;
    logic             o_valid, o_last, out_ready;
    logic [DW-1:0]    o_data;
    logic [1:0]       o_id;

    // Beat-interleave instance
    logic [NP-1:0]    il_valid, il_last, il_ready;
    logic [NP*DW-1:0] il_data;
    logic             il_ov, il_ol, il_oready;
    logic [DW-1:0]    il_od;
    logic [1:0]       il_oid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .LOCK_ON_LAST(1)) dut (
        .clk(clk), .rst(rst),
        .input_valid(in_valid), .input_data(in_data), .input_last(in_last), .input_ready(in_ready),
        .output_valid(o_valid), .output_data(o_data), .output_last(o_last), .output_id(o_id),
        .output_ready(out_ready)
    );

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .LOCK_ON_LAST(0)) dut_il (
        .clk(clk), .rst(rst),
        .input_valid(il_valid), .input_data(il_data), .input_last(il_last), .input_ready(il_ready),
        .output_valid(il_ov), .output_data(il_od), .output_last(il_ol), .output_id(il_oid),
        .output_ready(il_oready)
    );

    typedef struct {
        logic          rst;
        logic [3:0]    vld;
        logic [3:0]    lst;
        logic [39:0]   dat;
        logic          ordy;
        logic [3:0]    exp_rdy;
        logic          exp_ov;
        logic [9:0]    exp_od;
        logic          exp_ol;
        logic [1:0]    exp_id;
        logic          full;
    } vec_t;

    vec_t vecs[20];

    // Stream sources for multi-cycle sequences
    logic [9:0] src_d[4][8];
    logic       src_l[4][8];
    int         src_n[4];
    int         src_i[4];
    int         src_start[4];

    logic [9:0] exp_d[8];
    logic [1:0] exp_id[8];
    logic       exp_l[8];
    int         exp_n;

    logic [9:0] cap_d[$];
    logic [1:0] cap_id[$];
    logic       cap_l[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic [39:0] d, input logic ordy, input logic [3:0] erdy,
                                input logic eov, input logic [9:0] eod, input logic eol,
                                input logic [1:0] eid, input logic full);
        vec_t t;
        t.rst = r; t.vld = v; t.lst = l; t.dat = d; t.ordy = ordy;
        t.exp_rdy = erdy; t.exp_ov = eov; t.exp_od = eod; t.exp_ol = eol; t.exp_id = eid;
        t.full = full;
        return t;
    endfunction

    function automatic logic [39:0] d4(input logic [9:0] a, input logic [9:0] b,
                                       input logic [9:0] c, input logic [9:0] e);
        return {e, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        il_valid = '0; il_last = '0; il_data = '0; il_oready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clear_src();
        for (int p = 0; p < 4; p++) begin
            src_n[p] = 0; src_i[p] = 0; src_start[p] = 0;
        end
        cap_d.delete(); cap_id.delete(); cap_l.delete();
    endtask

    task automatic add_beat(input int p, input logic [9:0] d, input logic l);
        src_d[p][src_n[p]] = d;
        src_l[p][src_n[p]] = l;
        src_n[p]++;
    endtask

    task automatic set_exp(input int i, input logic [9:0] d, input logic [1:0] id, input logic l);
        exp_d[i] = d; exp_id[i] = id; exp_l[i] = l;
    endtask

    // Drives queued beats into one instance (output always ready) and records output beats
    task automatic run_streams(input bit il, input int cycles, input int drop_lo, input int drop_hi);
        logic [3:0]  v, l, r;
        logic [39:0] d;
        logic        ov, ol;
        logic [9:0]  od;
        logic [1:0]  oid;
        for (int c = 0; c < cycles; c++) begin
            v = '0; l = '0; d = '0;
            for (int p = 0; p < 4; p++) begin
                if (src_i[p] < src_n[p] && c >= src_start[p] &&
                    !(p == 1 && c >= drop_lo && c < drop_hi)) begin
                    v[p] = 1'b1;
                    l[p] = src_l[p][src_i[p]];
                    d[p*10 +: 10] = src_d[p][src_i[p]];
                end
            end
            if (il) begin
                il_valid = v; il_last = l; il_data = d;
            end else begin
                in_valid = v; in_last = l; in_data = d;
            end
            #1;
            r   = il ? il_ready : in_ready;
            ov  = il ? il_ov    : o_valid;
            od  = il ? il_od    : o_data;
            ol  = il ? il_ol    : o_last;
            oid = il ? il_oid   : o_id;
            if (c >= drop_lo && c < drop_hi) chk("drop_ready", 32'(r), 32'(0));
            if (c == drop_hi - 1) chk("drop_idle", 32'(ov), 32'(0));
            if (ov) begin
                cap_d.push_back(od); cap_id.push_back(oid); cap_l.push_back(ol);
            end
            for (int p = 0; p < 4; p++) begin
                if (v[p] && r[p]) src_i[p]++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic check_caps(input string tag);
        chk({tag, "_count"}, 32'(cap_d.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (i < cap_d.size()) begin
                chk({tag, "_data"}, 32'(cap_d[i]),  32'(exp_d[i]));
                chk({tag, "_id"},   32'(cap_id[i]), 32'(exp_id[i]));
                chk({tag, "_last"}, 32'(cap_l[i]),  32'(exp_l[i]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: single producer, reset gating, round robin with wrap, backpressure
        vecs[0]  = mk(1, 4'b1111, 4'b0000, 40'h0, 1, 4'b0000, 0, 10'h000, 0, 2'd0, 1);
        vecs[1]  = mk(0, 4'b0100, 4'b0000, d4(0, 0, 10'h001, 0), 1, 4'b0100, 0, 10'h000, 0, 2'd0, 1);
        vecs[2]  = mk(0, 4'b0100, 4'b0000, d4(0, 0, 10'h002, 0), 1, 4'b0100, 1, 10'h001, 0, 2'd2, 1);
        vecs[3]  = mk(0, 4'b0100, 4'b0000, d4(0, 0, 10'h003, 0), 1, 4'b0100, 1, 10'h002, 0, 2'd2, 1);
        vecs[4]  = mk(0, 4'b0100, 4'b0000, d4(0, 0, 10'h004, 0), 1, 4'b0100, 1, 10'h003, 0, 2'd2, 1);
        vecs[5]  = mk(0, 4'b0100, 4'b0100, d4(0, 0, 10'h005, 0), 1, 4'b0100, 1, 10'h004, 0, 2'd2, 1);
        vecs[6]  = mk(0, 4'b0000, 4'b0000, 40'h0, 1, 4'b0000, 1, 10'h005, 1, 2'd2, 1);
        vecs[7]  = mk(1, 4'b1111, 4'b1111, d4(10'h100, 10'h101, 10'h102, 10'h103), 1,
                      4'b0000, 0, 10'h000, 0, 2'd0, 0);
        vecs[8]  = mk(0, 4'b1111, 4'b1111, d4(10'h100, 10'h101, 10'h102, 10'h103), 1,
                      4'b0001, 0, 10'h000, 0, 2'd0, 1);
        vecs[9]  = mk(0, 4'b1111, 4'b1111, d4(10'h100, 10'h101, 10'h102, 10'h103), 1,
                      4'b0010, 1, 10'h100, 1, 2'd0, 1);
        vecs[10] = mk(0, 4'b1111, 4'b1111, d4(10'h100, 10'h101, 10'h102, 10'h103), 1,
                      4'b0100, 1, 10'h101, 1, 2'd1, 1);
        vecs[11] = mk(0, 4'b1111, 4'b1111, d4(10'h100, 10'h101, 10'h102, 10'h103), 1,
                      4'b1000, 1, 10'h102, 1, 2'd2, 1);
        vecs[12] = mk(0, 4'b1111, 4'b1111, d4(10'h100, 10'h101, 10'h102, 10'h103), 1,
                      4'b0001, 1, 10'h103, 1, 2'd3, 1);
        vecs[13] = mk(0, 4'b1111, 4'b1111, d4(10'h100, 10'h101, 10'h102, 10'h103), 1,
                      4'b0010, 1, 10'h100, 1, 2'd0, 1);
        vecs[14] = mk(0, 4'b1010, 4'b1010, d4(0, 10'h0A1, 0, 10'h0A3), 1, 4'b1000, 1, 10'h101, 1, 2'd1, 1);
        vecs[15] = mk(0, 4'b1010, 4'b1010, d4(0, 10'h0A1, 0, 10'h0A3), 0, 4'b0000, 1, 10'h0A3, 1, 2'd3, 1);
        vecs[16] = mk(0, 4'b1010, 4'b1010, d4(0, 10'h0A1, 0, 10'h0A3), 0, 4'b0000, 1, 10'h0A3, 1, 2'd3, 1);
        vecs[17] = mk(0, 4'b1010, 4'b1010, d4(0, 10'h0A1, 0, 10'h0A3), 1, 4'b0010, 1, 10'h0A3, 1, 2'd3, 1);
        vecs[18] = mk(0, 4'b0000, 4'b0000, 40'h0, 1, 4'b0000, 1, 10'h0A1, 1, 2'd1, 1);
        vecs[19] = mk(0, 4'b0000, 4'b0000, 40'h0, 1, 4'b0000, 0, 10'h000, 0, 2'd0, 0);

        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            rst       = vecs[i].rst;
            in_valid  = vecs[i].vld;
            in_last   = vecs[i].lst;
            in_data   = vecs[i].dat;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            chk($sformatf("v%0d_ovalid", i), 32'(o_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].full) begin
                chk($sformatf("v%0d_odata", i), 32'(o_data), 32'(vecs[i].exp_od));
                chk($sformatf("v%0d_olast", i), 32'(o_last), 32'(vecs[i].exp_ol));
                chk($sformatf("v%0d_oid", i),   32'(o_id),   32'(vecs[i].exp_id));
            end
            @(posedge clk); #1;
        end

        // Packet lock: port-1 packet stays contiguous ahead of port 0
        do_reset();
        clear_src();
        add_beat(1, 10'h011, 0); add_beat(1, 10'h012, 0); add_beat(1, 10'h013, 1);
        add_beat(0, 10'h001, 1); add_beat(0, 10'h002, 1);
        src_start[0] = 1;
        run_streams(0, 8, -1, -1);
        exp_n = 5;
        set_exp(0, 10'h011, 2'd1, 0); set_exp(1, 10'h012, 2'd1, 0); set_exp(2, 10'h013, 2'd1, 1);
        set_exp(3, 10'h001, 2'd0, 1); set_exp(4, 10'h002, 2'd0, 1);
        check_caps("lock");

        // Beat interleave: same stimulus, grants alternate
        do_reset();
        clear_src();
        add_beat(1, 10'h011, 0); add_beat(1, 10'h012, 0); add_beat(1, 10'h013, 1);
        add_beat(0, 10'h001, 1); add_beat(0, 10'h002, 1);
        src_start[0] = 1;
        run_streams(1, 8, -1, -1);
        exp_n = 5;
        set_exp(0, 10'h011, 2'd1, 0); set_exp(1, 10'h001, 2'd0, 1); set_exp(2, 10'h012, 2'd1, 0);
        set_exp(3, 10'h002, 2'd0, 1); set_exp(4, 10'h013, 2'd1, 1);
        check_caps("ilv");

        // Lock with a 2-cycle valid gap on the locked port: no bubble fill from port 0
        do_reset();
        clear_src();
        add_beat(1, 10'h011, 0); add_beat(1, 10'h012, 0); add_beat(1, 10'h013, 1);
        add_beat(0, 10'h001, 1);
        src_start[0] = 1;
        run_streams(0, 9, 1, 3);
        exp_n = 4;
        set_exp(0, 10'h011, 2'd1, 0); set_exp(1, 10'h012, 2'd1, 0); set_exp(2, 10'h013, 2'd1, 1);
        set_exp(3, 10'h001, 2'd0, 1);
        check_caps("gap");

        // Reset after the 2nd beat of a 4-beat port-3 packet
        do_reset();
        in_valid = 4'b1000; in_last = 4'b0000; in_data = d4(0, 0, 0, 10'h031);
        #1;
        chk("mrst_rdy0", 32'(in_ready), 32'(4'b1000));
        @(posedge clk); #1;
        in_data = d4(0, 0, 0, 10'h032);
        #1;
        chk("mrst_rdy1", 32'(in_ready), 32'(4'b1000));
        chk("mrst_od1", 32'(o_data), 32'(10'h031));
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 4'b1001; in_last = 4'b0001; in_data = d4(10'h0B0, 0, 0, 10'h033);
        #1;
        chk("mrst_rdy_in_rst", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mrst_ovalid", 32'(o_valid), 32'(0));
        chk("mrst_grant0", 32'(in_ready), 32'(4'b0001));
        @(posedge clk); #1;
        chk("mrst_out_id", 32'(o_id), 32'(0));
        chk("mrst_out_data", 32'(o_data), 32'(10'h0B0));
        idle_inputs();
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Shares one downstream AXIS consumer between NUM_PORTS upstream AXIS producers, e.g. several generators feeding one inline checker or core input.
- Fair round-robin arbitration; with LOCK_ON_LAST=1 a granted port keeps the output until its beat with last=1 transfers, so packets never interleave.
- Single registered output stage: no combinational path from output_ready to output_valid or data.
- Output carries the source port index so downstream checkers can demultiplex.

Parameters:
- DATA_WIDTH, 10: payload width per port.
- NUM_PORTS, 4: number of input streams, 2..16.
- LOCK_ON_LAST, 1: 1 = packet-level arbitration; 0 = re-arbitrate every beat and ignore last for grant purposes.
- ID_WIDTH, $clog2(NUM_PORTS): width of output_id. Minimum 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- input_valid  in  NUM_PORTS  per-port valid.
- input_data  in  NUM_PORTS*DATA_WIDTH  packed; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- input_last  in  NUM_PORTS  per-port end-of-packet.
- input_ready  out  NUM_PORTS  per-port ready; one-hot or zero.
- output_valid  out  1  output register holds a beat.
- output_data  out  DATA_WIDTH  registered payload.
- output_last  out  1  registered last.
- output_id  out  ID_WIDTH  index of the port that supplied the beat.
- output_ready  in  1  downstream ready.

Behaviour:
- Reset state, sampled on the clk edge with rst=1:
  - output_valid=0; output_data, output_last and output_id = 0.
  - state=IDLE; rr pointer=0, so port 0 has highest priority.
  - input_ready=0 while rst=1.
- Accept condition: accept = !output_valid || output_ready. The output stage holds 1 beat.
- IDLE grant: the first asserted input_valid scanning ports ptr, ptr+1, …, ptr+NUM_PORTS-1 (mod NUM_PORTS). The grant is combinational.
- LOCKED grant: fixed to lock_port regardless of other valids. If lock_port is not valid, no port is ready and no bubble is filled from other ports.
- Ready: input_ready[g] = accept && input_valid[g] for granted g; all other bits are 0. input_ready never depends on output_valid of the same cycle except via accept.
- Transfer on port g (input_valid[g] && input_ready[g]):
  - Register loads data, last and id=g; output_valid=1.
  - ptr <= (g+1) mod NUM_PORTS.
  - LOCK_ON_LAST=1: if input_last[g]=0, state becomes LOCKED with lock_port=g. If last=1, state becomes IDLE.
  - LOCK_ON_LAST=0: state stays IDLE and ptr still advances each beat.
- In LOCKED state ptr still updates only on transfer, so after the packet ends the next port after g wins.
- Output handshake:
  - output_valid && output_ready with no new load: output_valid <= 0.
  - Simultaneous consume and load: register replaced and output_valid stays 1. Full throughput is 1 beat/cycle.
  - While output_valid && !output_ready: data, last and id are held stable and all input_ready=0.
- Latency: input transfer at cycle n gives output_valid at cycle n+1.
- Boundary cases:
  - No valids: nothing granted, state unchanged.
  - Single active port: streams at 1 beat/cycle.
  - ptr wraps from NUM_PORTS-1 to 0.
  - A 1-beat packet (last=1 on first beat) never enters LOCKED.
- Reset mid-packet: lock and output beat are discarded with no flush. Upstream is responsible for restarting.
- Simulation-only assertions, excluded from synthesis:
  - input_ready is $onehot0.
  - Output stability while stalled.

Test Plan:
- Single producer: port 2 sends 5 beats 0x001..0x005, last on 0x005, output_ready=1. Response: output gives the same data in order, 1/cycle, id=2, first output one cycle after the first transfer, last on 0x005.
- Round robin: all 4 ports valid continuously with 1-beat packets, port p data=0x100+p. Response: id sequence 0,1,2,3,0,1,… with no skipped or repeated port.
- Packet lock (LOCK_ON_LAST=1): port 1 sends 3-beat packet 0x011,0x012,0x013 while port 0 is valid. Response: all 3 port-1 beats are contiguous; the port-0 beat follows. If port 1 drops valid mid-packet for 2 cycles, the output idles and port 0 does not get ready.
- Beat interleave (LOCK_ON_LAST=0): same stimulus as the packet-lock test. Response: output ids alternate 1,0,1,0,… until the port-0 queue drains.
- Backpressure: output_ready toggles 1,0,0,1 with 2 ports valid. Response: output_data, output_last and output_id are unchanged during the low cycles; input_ready is all 0 when stalled; no beat is lost or duplicated (scoreboard count matches).
- Reset mid-packet: rst=1 for 1 cycle after the 2nd beat of a 4-beat port-3 packet. Response: next cycle output_valid=0, state IDLE, port 0 has highest priority (with ports 0 and 3 valid, port 0 is granted first).
